// File: rtl/mfcc_pkg.sv
// Shared constants and helpers for the MFCC front end: ln2 scale, default
// parameters, the log2 mantissa table generator and 16-bit saturation.
package mfcc_pkg;

  localparam int LN2_Q16      = 45426;
  localparam int Q_L_DEF      = 11;
  localparam int IN_FRAC_DEF  = 16;
  localparam int N_MEL_DEF    = 32;
  localparam int LUT_BITS_DEF = 6;

  // Residual width used by the interpolating build.
  localparam int RES_BITS = 8;

  // log2 is carried as signed Q6.16 with one guard bit on the integer part.
  localparam int L2_FRAC = 16;
  localparam int EXP_W   = 7;
  localparam int L2_W    = EXP_W + L2_FRAC;
  localparam int ENTRY_W = L2_FRAC + 1;
  localparam int PROD_W  = 40;

  localparam logic signed [PROD_W-1:0] SAT_MAX = 32767;
  localparam logic signed [PROD_W-1:0] SAT_MIN = -32768;

  // round(log2(1 + i / 2^lut_bits) * 2^16) by repeated squaring in Q2.30;
  // i == 2^lut_bits yields exactly 65536, the interpolation end point.
  function automatic logic [ENTRY_W-1:0] log2_lut_entry(input int unsigned i,
                                                        input int unsigned lut_bits);
    logic [63:0] x;
    logic [20:0] acc;
    x   = ((64'd1 << lut_bits) + 64'(i)) << (30 - lut_bits);
    acc = '0;
    for (int b = 0; b < 20; b++) begin
      x   = (x * x) >> 30;
      acc = {acc[19:0], 1'b0};
      if (x >= (64'd2 << 30)) begin
        acc[0] = 1'b1;
        x      = x >> 1;
      end
    end
    return ENTRY_W'((acc + 21'd8) >> 4);
  endfunction

  function automatic logic [15:0] sat16(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX) return 16'h7FFF;
    if (v < SAT_MIN) return 16'h8000;
    return v[15:0];
  endfunction

endpackage

// File: rtl/lead_one_det32.sv
// Combinational 32-bit priority encoder: index of the most significant set
// bit, plus a flag for an all-zero input (index reads 0 in that case).
module lead_one_det32 (
  input  logic [31:0] i_x,
  output logic [4:0]  o_p,
  output logic        o_zero
);

  // NOTE: o_p gets a default before the loop so no path leaves it unassigned
  // and no latch is inferred; later iterations override, so the highest set
  // bit wins.
  always_comb begin
    o_p = '0;
    for (int i = 0; i < 32; i++) begin
      if (i_x[i]) o_p = 5'(i);
    end
  end

  assign o_zero = (i_x == '0);

endmodule

// File: rtl/log_compress.sv
// Streaming ln() of mel filterbank energies, fixed 4-cycle latency, with a
// band counter flagging the last band of each frame. Build option
// LOG_INTERP_EN enables linear interpolation between log2 table entries.
module log_compress
  import mfcc_pkg::*;
#(
  parameter int Q_L      = Q_L_DEF,
  parameter int IN_FRAC  = IN_FRAC_DEF,
  parameter int N_MEL    = N_MEL_DEF,
  parameter int LUT_BITS = LUT_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] energy_in,
  input  logic        data_valid,
  output logic [15:0] log_out,
  output logic        log_valid,
  output logic        log_last
);

  localparam int SHIFT = 32 - Q_L;
  localparam int CNT_W = (N_MEL > 1) ? $clog2(N_MEL) : 1;
`ifdef LOG_INTERP_EN
  localparam int FRAC_W = LUT_BITS + RES_BITS;
  localparam int LUT_N  = (1 << LUT_BITS) + 1;
`else
  localparam int FRAC_W = LUT_BITS;
  localparam int LUT_N  = 1 << LUT_BITS;
`endif
  localparam logic signed [PROD_W-1:0] LN2_W = PROD_W'(LN2_Q16);
  localparam logic signed [PROD_W-1:0] RND_W = PROD_W'(1) <<< (SHIFT - 1);

  // Constant log2 mantissa table, folded at elaboration.
  logic [ENTRY_W-1:0] w_lut [LUT_N];
  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    assign w_lut[g] = log2_lut_entry(g, LUT_BITS);
  end

  logic                     r_run;
  logic                     r_v1, r_v2, r_v3, r_v4;
  logic                     w_in_valid;
  logic [4:0]               w_p1;
  logic                     w_zero1;
  logic [31:0]              r_x1;
  logic [4:0]               r_p1, r_p2;
  logic                     r_zero1, r_zero2, r_zero3, r_zero4;
  logic [FRAC_W-1:0]        w_frac;
  logic [LUT_BITS-1:0]      w_idx, r_idx2;
  logic signed [EXP_W-1:0]  w_exp;
  logic [ENTRY_W-1:0]       w_mant;
  logic signed [L2_W-1:0]   w_l2, r_l2;
  logic signed [PROD_W-1:0] w_l2x, w_prod, r_prod4, w_rnd;
  logic [CNT_W-1:0]         r_band_cnt;
  logic                     w_band_end;

  // The first edge after reset release only arms the pipeline input.
  assign w_in_valid = data_valid & r_run;

  lead_one_det32 u_lod (
    .i_x    (energy_in),
    .o_p    (w_p1),
    .o_zero (w_zero1)
  );

  // S2: normalise so the leading one sits at bit 31, keep the bits below it.
  assign w_frac = FRAC_W'((r_x1 << (5'd31 - r_p1)) >> (31 - FRAC_W));
  assign w_idx  = w_frac[FRAC_W-1 -: LUT_BITS];

`ifdef LOG_INTERP_EN
  logic [RES_BITS-1:0]          w_res, r_res2;
  logic [LUT_BITS:0]            w_idx_hi;
  logic [ENTRY_W-1:0]           w_diff;
  logic [ENTRY_W+RES_BITS-1:0]  w_step;

  assign w_res    = w_frac[RES_BITS-1:0];
  assign w_idx_hi = {1'b0, r_idx2} + 1'b1;
  assign w_diff   = w_lut[w_idx_hi] - w_lut[r_idx2];
  assign w_step   = w_diff * r_res2;
  assign w_mant   = w_lut[r_idx2] + ENTRY_W'(w_step >> RES_BITS);
`else
  assign w_mant   = w_lut[r_idx2];
`endif

  // S3: integer part of log2 is the leading-one position less the input scale.
  assign w_exp = EXP_W'(r_p2) - EXP_W'(IN_FRAC);
  assign w_l2  = $signed({w_exp, {L2_FRAC{1'b0}}}) + $signed(L2_W'(w_mant));

  // S4: ln = log2 * ln2, then round half-up down to Q_L fraction bits.
  assign w_l2x  = PROD_W'(r_l2);
  assign w_prod = w_l2x * LN2_W;
  assign w_rnd  = (r_prod4 + RND_W) >>> SHIFT;

  assign w_band_end = (r_band_cnt == CNT_W'(N_MEL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_v4       <= 1'b0;
      log_valid  <= 1'b0;
      log_last   <= 1'b0;
      log_out    <= '0;
      r_band_cnt <= '0;
    end else begin
      r_run     <= 1'b1;
      r_v1      <= w_in_valid;
      r_v2      <= r_v1;
      r_v3      <= r_v2;
      r_v4      <= r_v3;
      log_valid <= r_v4;
      log_last  <= r_v4 && w_band_end;
      if (r_v4) begin
        log_out    <= r_zero4 ? 16'h8000 : sat16(w_rnd);
        r_band_cnt <= w_band_end ? '0 : r_band_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: datapath registers carry no reset; the reset valid chain already
  // marks their contents meaningless, so resetting them only costs routing.
  always_ff @(posedge clk) begin
    if (w_in_valid) begin
      r_x1    <= energy_in;
      r_p1    <= w_p1;
      r_zero1 <= w_zero1;
    end
    if (r_v1) begin
      r_idx2  <= w_idx;
      r_p2    <= r_p1;
      r_zero2 <= r_zero1;
`ifdef LOG_INTERP_EN
      r_res2  <= w_res;
`endif
    end
    if (r_v2) begin
      r_l2    <= w_l2;
      r_zero3 <= r_zero2;
    end
    if (r_v3) begin
      r_prod4 <= w_prod;
      r_zero4 <= r_zero3;
    end
  end

endmodule

// File: tb/tb_log_compress.sv
// Directed bench for log_compress: hand-computed ln values, frame markers,
// latency, gapped input and mid-frame reset.
module tb_log_compress;

  localparam int NV    = 11;
  localparam int N_MEL = 32;
`ifdef LOG_INTERP_EN
  localparam int EXP_FFFF = 22713;
  localparam int EXP_1P   = 16;
  localparam int TOL_1P   = 1;
`else
  localparam int EXP_FFFF = 22697;
  localparam int EXP_1P   = 0;
  localparam int TOL_1P   = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] energy_in = '0;
  logic        data_valid = 1'b0;
  logic [15:0] log_out;
  logic        log_valid;
  logic        log_last;

  always #5 clk = ~clk;

  log_compress dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .energy_in  (energy_in),
    .data_valid (data_valid),
    .log_out    (log_out),
    .log_valid  (log_valid),
    .log_last   (log_last)
  );

  typedef struct {
    int exp_val;
    int tol;
    bit last;
    int stamp;
  } exp_t;

  logic [31:0] vx [NV] = '{32'h0001_0000, 32'h0002_0000, 32'h0000_0001, 32'h0000_0000,
                           32'hFFFF_FFFF, 32'h0000_8000, 32'h0004_0000, 32'h8000_0000,
                           32'h0003_0000, 32'h0001_0200, 32'h0001_4000};
  int vexp [NV] = '{0, 1420, -22713, -32768, EXP_FFFF, -1420, 2839, 21293, 2250, EXP_1P, 457};
  int vtol [NV] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, TOL_1P, 0};

  exp_t q [$];
  exp_t e;
  int   out_idx  = 0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp_v,
                       input longint tol = 0);
    n_checks++;
    if (obs > exp_v + tol || obs < exp_v - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d",
               tag, obs, exp_v, tol, cyc);
    end
  endtask

  task automatic send(input int v);
    @(negedge clk);
    energy_in  = vx[v];
    data_valid = 1'b1;
    q.push_back('{vexp[v], vtol[v], (out_idx % N_MEL) == N_MEL - 1, cyc + 1});
    out_idx++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    idle(1);
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_empty", q.size(), 0);
  endtask

  // Release reset with data_valid already high; that sample must be dropped.
  task automatic release_with_valid();
    @(negedge clk);
    rst_n      = 1'b1;
    energy_in  = 32'h0002_0000;
    data_valid = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (log_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", log_valid, 0);
        end else begin
          e = q.pop_front();
          check("log_out", $signed(log_out), e.exp_val, e.tol);
          check("log_last", log_last, e.last);
          check("latency", cyc - e.stamp, 4);
        end
      end else begin
        check("last_without_valid", log_last, 0);
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", log_valid, 0);
    check("rst_last", log_last, 0);
    check("rst_out", log_out, 0);
    release_with_valid();

    // Three back-to-back frames: markers on outputs 31, 63 and 95.
    for (int i = 0; i < 3 * N_MEL; i++) send(i % NV);
    drain();

    // Isolated directed vectors.
    for (int i = 0; i < NV; i++) begin
      send(i);
      idle(6);
    end
    drain();

    // Random idle gaps between samples.
    for (int i = 0; i < 40; i++) begin
      send((i * 7) % NV);
      idle($urandom_range(0, 3));
    end
    drain();

    // Mid-frame reset discards in-flight samples and restarts band counting.
    for (int i = 0; i < 10; i++) send(i);
    @(negedge clk);
    rst_n      = 1'b0;
    data_valid = 1'b0;
    q.delete();
    out_idx = 0;
    @(negedge clk);
    check("midrst_valid", log_valid, 0);
    check("midrst_out", log_out, 0);
    @(negedge clk);
    check("midrst_last", log_last, 0);
    release_with_valid();
    for (int i = 0; i < N_MEL; i++) send((i * 3) % NV);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
